// File: rtl/if_id_stage.sv
// IF stage PC register plus IF/ID pipeline register with a boot/redirect FSM.
// Optional macro FETCH_MISALIGN_EN traps misaligned redirect targets.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        PC_Stall,
  input  logic        IF_ID_Stall,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  input  logic [31:0] Imem_Instr,
  output logic [31:0] Imem_Addr,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_PC4,
  output logic        IF_ID_Valid,
  output logic [4:0]  IF_ID_rs1,
  output logic [4:0]  IF_ID_rs2,
  output logic [2:0]  opcode,
  output logic        Fetch_Misalign
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    REDIRECT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipc4_q, ipc4_d;
  logic        valid_q, valid_d;
  logic        br_mis;
  logic [31:0] br_pc;

  assign pc4   = pc_q + 32'd4;
  assign br_pc = {Branch_Target[31:2], 2'b00};

`ifdef FETCH_MISALIGN_EN
  logic mis_q, mis_d;

  assign br_mis = Branch_Taken
                & (Branch_Target[1:0] != 2'b00);
  assign mis_d  = mis_q | br_mis;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end

  assign Fetch_Misalign = mis_q;
`else
  logic unused_tgt_lsb;

  assign unused_tgt_lsb = ^Branch_Target[1:0];
  assign br_mis         = 1'b0;
  assign Fetch_Misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:     state_d = Branch_Taken ? REDIRECT : RUN;
      RUN:      state_d = Branch_Taken ? REDIRECT : RUN;
      REDIRECT: state_d = Branch_Taken ? REDIRECT : RUN;
      default:  state_d = BOOT;
    endcase
  end

  // Redirect wins over both stalls; BOOT holds the PC so
  // the first real capture carries RESET_PC.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    valid_d = valid_q;
    if (Branch_Taken) begin
      pc_d    = br_mis ? pc_q : br_pc;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (state_q == BOOT) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else begin
      if (!PC_Stall) begin
        pc_d = pc4;
      end
      if (!IF_ID_Stall) begin
        instr_d = Imem_Instr;
        ipc_d   = pc_q;
        ipc4_d  = pc4;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      ipc_q   <= 32'h0;
      ipc4_q  <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
      valid_q <= valid_d;
    end
  end

  assign Imem_Addr   = pc_q;
  assign IF_ID_Instr = instr_q;
  assign IF_ID_PC    = ipc_q;
  assign IF_ID_PC4   = ipc4_q;
  assign IF_ID_Valid = valid_q;
  assign IF_ID_rs1   = instr_q[19:15];
  assign IF_ID_rs2   = instr_q[24:20];
  assign opcode      = instr_q[6:4];

endmodule

// File: tb/tb_if_id_stage.sv
// Directed and random bench for if_id_stage against a
// behavioural fetch model.
module tb_if_id_stage;

  logic        CLK = 1'b0;
  logic        rst;
  logic        PC_Stall;
  logic        IF_ID_Stall;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic [31:0] Imem_Instr;
  logic [31:0] Imem_Addr;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_PC;
  logic [31:0] IF_ID_PC4;
  logic        IF_ID_Valid;
  logic [4:0]  IF_ID_rs1;
  logic [4:0]  IF_ID_rs2;
  logic [2:0]  opcode;
  logic        Fetch_Misalign;

  int vecs = 0;
  int fails = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_id_stage dut (
    .CLK(CLK),
    .rst(rst),
    .PC_Stall(PC_Stall),
    .IF_ID_Stall(IF_ID_Stall),
    .Branch_Taken(Branch_Taken),
    .Branch_Target(Branch_Target),
    .Imem_Instr(Imem_Instr),
    .Imem_Addr(Imem_Addr),
    .IF_ID_Instr(IF_ID_Instr),
    .IF_ID_PC(IF_ID_PC),
    .IF_ID_PC4(IF_ID_PC4),
    .IF_ID_Valid(IF_ID_Valid),
    .IF_ID_rs1(IF_ID_rs1),
    .IF_ID_rs2(IF_ID_rs2),
    .opcode(opcode),
    .Fetch_Misalign(Fetch_Misalign)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  assign Imem_Instr = imem(Imem_Addr);

  // Reference: architectural fetch state
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4;
  logic        m_valid, m_mis, m_boot;

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_ipc = 0; m_ipc4 = 0;
    m_valid = 0; m_mis = 0; m_boot = 1;
  endtask

  task automatic model_edge(input bit bt, input logic [31:0] tgt,
                            input bit ps, input bit is);
    logic mis;
`ifdef FETCH_MISALIGN_EN
    mis = (tgt % 4) != 0;
`else
    mis = 0;
`endif
    if (bt) begin
      if (!mis) m_pc = tgt - (tgt % 4);
      m_mis = m_mis | mis;
      m_instr = NOP; m_valid = 0;
    end else if (m_boot) begin
      m_instr = NOP; m_valid = 0;
    end else begin
      if (!is) begin
        m_instr = imem(m_pc); m_ipc = m_pc;
        m_ipc4 = m_pc + 4; m_valid = 1;
      end
      if (!ps) m_pc = m_pc + 4;
    end
    m_boot = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".addr"},  Imem_Addr, m_pc);
    chk({tag, ".instr"}, IF_ID_Instr, m_instr);
    chk({tag, ".pc"},    IF_ID_PC, m_ipc);
    chk({tag, ".pc4"},   IF_ID_PC4, m_ipc4);
    chk({tag, ".valid"}, 32'(IF_ID_Valid), 32'(m_valid));
    chk({tag, ".rs1"},   32'(IF_ID_rs1), 32'(m_instr[19:15]));
    chk({tag, ".rs2"},   32'(IF_ID_rs2), 32'(m_instr[24:20]));
    chk({tag, ".op"},    32'(opcode), 32'(m_instr[6:4]));
    chk({tag, ".mis"},   32'(Fetch_Misalign), 32'(m_mis));
  endtask

  task automatic step(input string tag, input bit bt,
                      input logic [31:0] tgt, input bit ps,
                      input bit is);
    Branch_Taken = bt; Branch_Target = tgt;
    PC_Stall = ps; IF_ID_Stall = is;
    @(posedge CLK);
    model_edge(bt, tgt, ps, is);
    #1;
    chk_all(tag);
  endtask

  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk_all(tag);
    @(negedge CLK);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; PC_Stall = 0; IF_ID_Stall = 0;
    Branch_Taken = 0; Branch_Target = 0;
    model_reset();
    #12;
    chk_all("reset");
    @(negedge CLK);
    rst = 1'b0;

    // reset release: boot bubble, then capture PC 0
    step("boot1", 0, 0, 0, 0);
    chk("boot1.valid0", 32'(IF_ID_Valid), 32'd0);
    chk("boot1.addr0", Imem_Addr, 32'h0);
    step("boot2", 0, 0, 0, 0);
    chk("boot2.valid1", 32'(IF_ID_Valid), 32'd1);
    chk("boot2.pc0", IF_ID_PC, 32'h0);
    chk("boot2.addr4", Imem_Addr, 32'h4);
    step("boot3", 0, 0, 0, 0);
    chk("boot3.addr8", Imem_Addr, 32'h8);
    step("run", 0, 0, 0, 0);
    step("run", 0, 0, 0, 0);
    chk("pre_stall.addr", Imem_Addr, 32'h10);

    // both stalls for 3 cycles at 0x10
    for (int i = 0; i < 3; i++) begin
      step("stall2", 0, 32'h0, 1, 1);
      chk("stall2.addr", Imem_Addr, 32'h10);
      chk("stall2.pc", IF_ID_PC, 32'hC);
    end
    step("resume", 0, 0, 0, 0);
    chk("resume.addr", Imem_Addr, 32'h14);
    step("run", 0, 0, 0, 0);
    step("run", 0, 0, 0, 0);
    step("run", 0, 0, 0, 0);
    chk("pre_br.addr", Imem_Addr, 32'h20);

    // taken branch to 0x100
    step("br", 1, 32'h100, 0, 0);
    chk("br.addr", Imem_Addr, 32'h100);
    chk("br.nop", IF_ID_Instr, NOP);
    chk("br.valid", 32'(IF_ID_Valid), 32'd0);
    step("br_after", 0, 0, 0, 0);
    chk("br_after.pc", IF_ID_PC, 32'h100);
    chk("br_after.valid", 32'(IF_ID_Valid), 32'd1);

    // redirect beats stalls
    step("br_stall", 1, 32'h300, 1, 1);
    chk("br_stall.addr", Imem_Addr, 32'h300);
    step("br_back", 1, 32'h340, 0, 0);
    step("run", 0, 0, 0, 0);

    // wrap at top of address space
    step("wrap_br", 1, 32'hFFFF_FFFC, 0, 0);
    step("wrap", 0, 0, 0, 0);
    chk("wrap.addr", Imem_Addr, 32'h0);
    chk("wrap.pc4", IF_ID_PC4, 32'h0);
    step("run", 0, 0, 0, 0);

    // misaligned target
    step("mis_pre", 1, 32'h80, 0, 0);
    step("mis", 1, 32'h102, 0, 0);
`ifdef FETCH_MISALIGN_EN
    chk("mis.flag", 32'(Fetch_Misalign), 32'd1);
    chk("mis.addr", Imem_Addr, 32'h80);
`else
    chk("mis.flag", 32'(Fetch_Misalign), 32'd0);
    chk("mis.addr", Imem_Addr, 32'h100);
`endif
    step("run", 0, 0, 0, 0);

    // reset in the middle of a redirect with stalls pending
    step("pre_rst", 1, 32'h500, 1, 1);
    do_reset("mid_rst");
    step("boot1b", 0, 0, 0, 0);
    step("boot2b", 0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit bt, ps, is;
      logic [31:0] tgt;
      bt  = ($urandom_range(0, 7) == 0);
      ps  = ($urandom_range(0, 3) == 0);
      is  = ($urandom_range(0, 3) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 5) != 0) tgt[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF8;
      step("rnd", bt, tgt, ps, is);
      if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, fails);
    $finish;
  end

endmodule
